reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- RV32I integer register file: 32 architectural registers, each 32 bits wide.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Register x0 is hardwired to zero.
- Sits in the CPU datapath between decode (register indices) and execute/writeback (operands, result).

Parameters:
- None. Geometry is fixed at 32 registers x 32 bits.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- write  input  1  write enable for the rd port.
- rs1  input  5  read port 1 register index.
- rs2  input  5  read port 2 register index.
- rd  input  5  write port register index.
- writedata  input  32  data written to register rd.
- readdata_1  output  32  contents of register rs1.
- readdata_2  output  32  contents of register rs2.

Behaviour:
- Storage:
  - 31 physical 32-bit registers, named x1..x31, each individually visible by hierarchical name (for example dut.x20).
  - x0 has no storage. It is a constant zero, also visible as x0.
- Reset:
  - reset_n low clears x1..x31 to 32'h0 immediately, without waiting for a clock edge.
  - Reset has priority over any write in progress.
  - readdata_1 and readdata_2 follow the cleared contents combinationally, so both read 0 during and after reset.
- Write:
  - On a clk rising edge with reset_n high and write = 1, register x[rd] takes writedata.
  - Single-cycle latency: the new value is visible from just after that edge.
  - rd = 0 with write = 1 is a no-op; x0 stays 0.
  - write = 0: no register changes, whatever rd and writedata hold.
  - Changing rd or writedata without a clock edge never modifies state.
- Read:
  - Purely combinational: readdata_1 = x[rs1], readdata_2 = x[rs2], updated in the same delta as an index or contents change.
  - Index 0 returns 32'h0 on both ports.
  - rs1 = rs2 is legal; both ports return the same value.
- Read/write same register, same cycle (without the optional feature):
  - The read returns the old value until the clock edge, then the new value.
- Reset mid-operation:
  - Asserting reset_n between edges clears the registers at once.
  - A write pending for the next edge is lost if reset_n is still low at that edge.
- Undriven inputs (X or Z) on rs1/rs2 may produce X on the outputs. No X may propagate into storage unless write = 1.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through forwarding on both read ports.
  - Condition: write = 1, rd != 0 and rd == rs1 (or rd == rs2).
  - The matching port outputs writedata combinationally, before the clock edge.
  - Storage update timing is unchanged.
  - With rd = 0 there is no bypass; the port still reads 0.
- Undefined: no forwarding. Reads always reflect the stored contents.

Test Plan:
- Reset: pulse reset_n low for 2 time units with write = 0 -> x1..x31 read 32'h0 on both ports.
- Fill: for i = 0..31, rd = i, writedata = (i+1)*2, write pulsed for one edge each -> rs1 = 0 reads 32'h0; rs1 = 14 reads 30; rs2 = 29 reads 60.
- x0 write ignored: rd = 0, writedata = 32'hFFFF_FFFF, write = 1 for one edge -> readdata_1 and readdata_2 with index 0 read 32'h0.
- Write timing: rd = 20, writedata = 32'hF00D, write = 0 -> x20 unchanged (not F00D) before the edge. Assert write, one edge -> x20 == 32'hF00D and readdata_1 (rs1 = 20) == 32'hF00D.
- Write-enable gating: write = 0, vary rd/writedata across 3 edges -> no register changes.
- Async reset mid-run: after fill, drop reset_n between edges -> readdata_1 (rs1 = 31) reads 0 before the next edge. Release -> still 0. A new write then succeeds.
- (REG_FILE_BYPASS_EN) Bypass: rs1 = rd = 7, writedata = 32'h1234, write = 1 -> readdata_1 == 32'h1234 before the edge.

Source files
------------

// File: rtl/reg_file.sv
// RV32I integer register file: 32 x 32b, two combinational read ports, one write port; x0 reads zero.
// Reads are combinational (zero cycles); a write is visible from just after the rising edge that commits it.
// No backpressure: a write is accepted on every edge with write=1; define REG_FILE_BYPASS_EN for write-through forwarding.
module reg_file (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        write,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   input  logic [31:0] writedata,
   output logic [31:0] readdata_1,
   output logic [31:0] readdata_2
);

   // Architectural registers, kept as individual named signals so each is
   // reachable hierarchically (dut.x1 .. dut.x31). x0 has no storage.
   logic [31:0] x0;
   logic [31:0] x1,  x2,  x3,  x4,  x5,  x6,  x7,  x8;
   logic [31:0] x9,  x10, x11, x12, x13, x14, x15, x16;
   logic [31:0] x17, x18, x19, x20, x21, x22, x23, x24;
   logic [31:0] x25, x26, x27, x28, x29, x30, x31;

   // Indexed view used by both read muxes.
   logic [31:0] regs_q [32];

   assign x0 = 32'h0;

   assign regs_q[0]  = x0;
   assign regs_q[1]  = x1;
   assign regs_q[2]  = x2;
   assign regs_q[3]  = x3;
   assign regs_q[4]  = x4;
   assign regs_q[5]  = x5;
   assign regs_q[6]  = x6;
   assign regs_q[7]  = x7;
   assign regs_q[8]  = x8;
   assign regs_q[9]  = x9;
   assign regs_q[10] = x10;
   assign regs_q[11] = x11;
   assign regs_q[12] = x12;
   assign regs_q[13] = x13;
   assign regs_q[14] = x14;
   assign regs_q[15] = x15;
   assign regs_q[16] = x16;
   assign regs_q[17] = x17;
   assign regs_q[18] = x18;
   assign regs_q[19] = x19;
   assign regs_q[20] = x20;
   assign regs_q[21] = x21;
   assign regs_q[22] = x22;
   assign regs_q[23] = x23;
   assign regs_q[24] = x24;
   assign regs_q[25] = x25;
   assign regs_q[26] = x26;
   assign regs_q[27] = x27;
   assign regs_q[28] = x28;
   assign regs_q[29] = x29;
   assign regs_q[30] = x30;
   assign regs_q[31] = x31;

   // Storage: async clear wins over any write; otherwise commit writedata to x[rd] on the edge.
   // rd=0 falls into the default arm, so x0 is never written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x1  <= 32'h0; x2  <= 32'h0; x3  <= 32'h0; x4  <= 32'h0;
         x5  <= 32'h0; x6  <= 32'h0; x7  <= 32'h0; x8  <= 32'h0;
         x9  <= 32'h0; x10 <= 32'h0; x11 <= 32'h0; x12 <= 32'h0;
         x13 <= 32'h0; x14 <= 32'h0; x15 <= 32'h0; x16 <= 32'h0;
         x17 <= 32'h0; x18 <= 32'h0; x19 <= 32'h0; x20 <= 32'h0;
         x21 <= 32'h0; x22 <= 32'h0; x23 <= 32'h0; x24 <= 32'h0;
         x25 <= 32'h0; x26 <= 32'h0; x27 <= 32'h0; x28 <= 32'h0;
         x29 <= 32'h0; x30 <= 32'h0; x31 <= 32'h0;
      end else if (write) begin
         case (rd)
            5'd1:    x1  <= writedata;
            5'd2:    x2  <= writedata;
            5'd3:    x3  <= writedata;
            5'd4:    x4  <= writedata;
            5'd5:    x5  <= writedata;
            5'd6:    x6  <= writedata;
            5'd7:    x7  <= writedata;
            5'd8:    x8  <= writedata;
            5'd9:    x9  <= writedata;
            5'd10:   x10 <= writedata;
            5'd11:   x11 <= writedata;
            5'd12:   x12 <= writedata;
            5'd13:   x13 <= writedata;
            5'd14:   x14 <= writedata;
            5'd15:   x15 <= writedata;
            5'd16:   x16 <= writedata;
            5'd17:   x17 <= writedata;
            5'd18:   x18 <= writedata;
            5'd19:   x19 <= writedata;
            5'd20:   x20 <= writedata;
            5'd21:   x21 <= writedata;
            5'd22:   x22 <= writedata;
            5'd23:   x23 <= writedata;
            5'd24:   x24 <= writedata;
            5'd25:   x25 <= writedata;
            5'd26:   x26 <= writedata;
            5'd27:   x27 <= writedata;
            5'd28:   x28 <= writedata;
            5'd29:   x29 <= writedata;
            5'd30:   x30 <= writedata;
            5'd31:   x31 <= writedata;
            default: ;
         endcase
      end
   end

`ifdef REG_FILE_BYPASS_EN
   logic fwd_1_d;
   logic fwd_2_d;

   // Forward the in-flight write to a matching read port; rd=0 never forwards so x0 stays zero.
   always_comb begin
      fwd_1_d    = write && (rd != 5'd0) && (rd == rs1);
      fwd_2_d    = write && (rd != 5'd0) && (rd == rs2);
      readdata_1 = fwd_1_d ? writedata : regs_q[rs1];
      readdata_2 = fwd_2_d ? writedata : regs_q[rs2];
   end
`else
   // Plain combinational read of the stored contents.
   always_comb begin
      readdata_1 = regs_q[rs1];
      readdata_2 = regs_q[rs2];
   end
`endif

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

   logic        clk;
   logic        reset_n;
   logic        write;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] writedata;
   logic [31:0] readdata_1;
   logic [31:0] readdata_2;

   int vec_cnt;
   int err_cnt;

   reg_file dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .write      (write),
      .rs1        (rs1),
      .rs2        (rs2),
      .rd         (rd),
      .writedata  (writedata),
      .readdata_1 (readdata_1),
      .readdata_2 (readdata_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one write during the low phase, commit it on the next rising edge.
   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      rd        = a;
      writedata = d;
      write     = 1'b1;
      @(posedge clk);
      #1;
      write     = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #1;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         #1;
         vec_cnt++;
         if (readdata_1 !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_rd1 idx=%0d got=%h exp=%h", i, readdata_1, 32'h0);
         end
         vec_cnt++;
         if (readdata_2 !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_rd2 idx=%0d got=%h exp=%h", 31 - i, readdata_2, 32'h0);
         end
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 32; i++) do_write(5'(i), 32'((i + 1) * 2));
      rs1 = 5'd0; rs2 = 5'd29;
      #1;
      vec_cnt++;
      if (readdata_1 !== 32'h0) begin
         err_cnt++;
         $display("FAIL fill_x0 got=%h exp=%h", readdata_1, 32'h0);
      end
      vec_cnt++;
      if (readdata_2 !== 32'd60) begin
         err_cnt++;
         $display("FAIL fill_x29 got=%h exp=%h", readdata_2, 32'd60);
      end
      rs1 = 5'd14;
      #1;
      vec_cnt++;
      if (readdata_1 !== 32'd30) begin
         err_cnt++;
         $display("FAIL fill_x14 got=%h exp=%h", readdata_1, 32'd30);
      end
      for (int i = 1; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(i);
         #1;
         vec_cnt++;
         if (readdata_1 !== 32'((i + 1) * 2) || readdata_2 !== 32'((i + 1) * 2)) begin
            err_cnt++;
            $display("FAIL fill_all idx=%0d got=%h/%h exp=%h", i, readdata_1, readdata_2, 32'((i + 1) * 2));
         end
      end
   endtask

   task automatic test_x0_write();
      do_write(5'd0, 32'hFFFF_FFFF);
      rs1 = 5'd0; rs2 = 5'd0;
      #1;
      vec_cnt++;
      if (readdata_1 !== 32'h0) begin
         err_cnt++;
         $display("FAIL x0_rd1 got=%h exp=%h", readdata_1, 32'h0);
      end
      vec_cnt++;
      if (readdata_2 !== 32'h0) begin
         err_cnt++;
         $display("FAIL x0_rd2 got=%h exp=%h", readdata_2, 32'h0);
      end
      rs1 = 5'd1;
      #1;
      vec_cnt++;
      if (readdata_1 !== 32'd4) begin
         err_cnt++;
         $display("FAIL x0_spill_x1 got=%h exp=%h", readdata_1, 32'd4);
      end
   endtask

   task automatic test_write_timing();
      @(negedge clk);
      rd = 5'd20; writedata = 32'hF00D; write = 1'b0; rs1 = 5'd20;
      #1;
      vec_cnt++;
      if (dut.x20 !== 32'd42) begin
         err_cnt++;
         $display("FAIL wt_before_en got=%h exp=%h", dut.x20, 32'd42);
      end
      write = 1'b1;
      #1;
      vec_cnt++;
`ifdef REG_FILE_BYPASS_EN
      if (readdata_1 !== 32'hF00D) begin
         err_cnt++;
         $display("FAIL wt_pre_edge_fwd got=%h exp=%h", readdata_1, 32'hF00D);
      end
`else
      if (readdata_1 !== 32'd42) begin
         err_cnt++;
         $display("FAIL wt_pre_edge_old got=%h exp=%h", readdata_1, 32'd42);
      end
`endif
      vec_cnt++;
      if (dut.x20 !== 32'd42) begin
         err_cnt++;
         $display("FAIL wt_store_pre_edge got=%h exp=%h", dut.x20, 32'd42);
      end
      @(posedge clk);
      #1;
      write = 1'b0;
      vec_cnt++;
      if (dut.x20 !== 32'hF00D) begin
         err_cnt++;
         $display("FAIL wt_store_post got=%h exp=%h", dut.x20, 32'hF00D);
      end
      vec_cnt++;
      if (readdata_1 !== 32'hF00D) begin
         err_cnt++;
         $display("FAIL wt_read_post got=%h exp=%h", readdata_1, 32'hF00D);
      end
   endtask

   task automatic test_write_gating();
      write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rd = 5'(5 + i);
         writedata = 32'hBAD0_0000 + 32'(i);
      end
      @(posedge clk);
      #1;
      // Glitch rd/write between edges; the write is withdrawn before the edge.
      @(negedge clk);
      write = 1'b1; rd = 5'd9; writedata = 32'hDEAD;
      #1 rd = 5'd10;
      #1 writedata = 32'hBEEF;
      #1 write = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 5; i <= 10; i++) begin
         if (i == 8) continue;
         rs2 = 5'(i);
         #1;
         vec_cnt++;
         if (readdata_2 !== 32'((i + 1) * 2)) begin
            err_cnt++;
            $display("FAIL gating idx=%0d got=%h exp=%h", i, readdata_2, 32'((i + 1) * 2));
         end
      end
   endtask

   task automatic test_back_to_back();
      do_write(5'd3, 32'h1111_0003);
      do_write(5'd4, 32'h2222_0004);
      do_write(5'd3, 32'h3333_0003);
      rs1 = 5'd3; rs2 = 5'd4;
      #1;
      vec_cnt++;
      if (readdata_1 !== 32'h3333_0003) begin
         err_cnt++;
         $display("FAIL b2b_x3 got=%h exp=%h", readdata_1, 32'h3333_0003);
      end
      vec_cnt++;
      if (readdata_2 !== 32'h2222_0004) begin
         err_cnt++;
         $display("FAIL b2b_x4 got=%h exp=%h", readdata_2, 32'h2222_0004);
      end
   endtask

   task automatic test_async_reset();
      rs1 = 5'd31; rs2 = 5'd14;
      @(posedge clk);
      #2;
      write = 1'b1; rd = 5'd31; writedata = 32'hABCD;
      reset_n = 1'b0;
      #1;
      write = 1'b0;
      vec_cnt++;
      if (readdata_1 !== 32'h0) begin
         err_cnt++;
         $display("FAIL arst_immediate got=%h exp=%h", readdata_1, 32'h0);
      end
      write = 1'b1;
      @(posedge clk);
      #1;
      write = 1'b0;
      vec_cnt++;
      if (dut.x31 !== 32'h0) begin
         err_cnt++;
         $display("FAIL arst_write_lost got=%h exp=%h", dut.x31, 32'h0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      vec_cnt++;
      if (readdata_1 !== 32'h0 || readdata_2 !== 32'h0) begin
         err_cnt++;
         $display("FAIL arst_release got=%h/%h exp=%h", readdata_1, readdata_2, 32'h0);
      end
      do_write(5'd31, 32'h5A5A_5A5A);
      #1;
      vec_cnt++;
      if (readdata_1 !== 32'h5A5A_5A5A) begin
         err_cnt++;
         $display("FAIL arst_new_write got=%h exp=%h", readdata_1, 32'h5A5A_5A5A);
      end
   endtask

`ifdef REG_FILE_BYPASS_EN
   task automatic test_bypass();
      @(negedge clk);
      rs1 = 5'd7; rs2 = 5'd0; rd = 5'd7; writedata = 32'h1234; write = 1'b1;
      #1;
      vec_cnt++;
      if (readdata_1 !== 32'h1234) begin
         err_cnt++;
         $display("FAIL bypass_rd1 got=%h exp=%h", readdata_1, 32'h1234);
      end
      vec_cnt++;
      if (dut.x7 !== 32'h0) begin
         err_cnt++;
         $display("FAIL bypass_store_early got=%h exp=%h", dut.x7, 32'h0);
      end
      rd = 5'd0;
      #1;
      vec_cnt++;
      if (readdata_2 !== 32'h0) begin
         err_cnt++;
         $display("FAIL bypass_x0 got=%h exp=%h", readdata_2, 32'h0);
      end
      rd = 5'd7;
      @(posedge clk);
      #1;
      write = 1'b0;
      vec_cnt++;
      if (dut.x7 !== 32'h1234) begin
         err_cnt++;
         $display("FAIL bypass_store got=%h exp=%h", dut.x7, 32'h1234);
      end
   endtask
`endif

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      write     = 1'b0;
      rs1       = 5'd0;
      rs2       = 5'd0;
      rd        = 5'd0;
      writedata = 32'h0;
      reset_n   = 1'b1;
      test_reset();
      test_fill();
      test_x0_write();
      test_write_timing();
      test_write_gating();
      test_back_to_back();
      test_async_reset();
`ifdef REG_FILE_BYPASS_EN
      test_bypass();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
